// File: rtl/mac_seq_ctrl.sv
// Sequencer for a three-lane 8x8 MAC array: clears the lane accumulators, streams
// operand beats onto the lanes, waits out the MAC latency, then reports the lane sum.
module mac_seq_ctrl #(
  parameter int LEN_W   = 4,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_a,
  input  logic [23:0]      in_b,
  output logic [23:0]      lane_a,
  output logic [23:0]      lane_b,
  output logic             acc_clr,
  output logic             acc_en,
  input  logic [47:0]      acc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_sum
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [2:0]       drain_q;
  logic             vld_p1;
  logic             start_ok;
  logic             start_bad;
  logic             beat_acc;
  logic             last_beat;
  logic             drain_end;

  function automatic logic [17:0] lane_sum(input logic [47:0] acc);
    return {2'b00, acc[15:0]} + {2'b00, acc[31:16]} + {2'b00, acc[47:32]};
  endfunction

  assign busy      = (state != IDLE);
  assign acc_clr   = (state == CLEAR);
  assign out_valid = (state == DONE);
  assign in_ready  = (state == RUN) && (cnt_q < len_q);
  assign acc_en    = vld_p1;

  // Abort outranks every other event, so it masks starts, beats and the sum capture.
  assign start_ok  = !abort && (state == IDLE) && start && (len != '0);
  assign start_bad = !abort && (state == IDLE) && start && (len == '0);
  assign beat_acc  = !abort && in_valid && in_ready;
  assign last_beat = beat_acc && (cnt_q == len_q - 1'b1);
  assign drain_end = !abort && (state == DRAIN) && (drain_q == DRAIN_LAST);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = CLEAR;
        CLEAR:   state_nxt = RUN;
        RUN:     if (last_beat) state_nxt = DRAIN;
        DRAIN:   if (drain_end) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= start_bad;
      if (start_ok) begin
        len_q <= len;
        cnt_q <= '0;
      end else if (beat_acc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // DRAIN is entered on the cycle of the final acc_en; count MAC_LAT more cycles.
      if ((state == DRAIN) && (state_nxt == DRAIN)) drain_q <= drain_q + 1'b1;
      else                                          drain_q <= '0;
    end
  end

  // p0 -> p1: accepted beat lands on the lanes together with its accumulate strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      lane_a <= '0;
      lane_b <= '0;
    end else begin
      vld_p1 <= beat_acc;
      if (beat_acc) begin
        lane_a <= in_a;
        lane_b <= in_b;
      end
    end
  end

  // accumulator settle -> result register, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum <= '0;
    end else if (drain_end) begin
      out_sum <= lane_sum(acc_in);
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a behavioural three-lane MAC (MAC_LAT=1), a table of jobs
// with a result scoreboard, and hand sequences for error, abort and reset corners.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        abort;
  logic        busy;
  logic        err;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic [23:0] lane_a;
  logic [23:0] lane_b;
  logic        acc_clr;
  logic        acc_en;
  logic [47:0] acc_in;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sum;

  mac_seq_ctrl #(.LEN_W(4), .MAC_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .err(err), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .lane_a(lane_a), .lane_b(lane_b),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane accumulators: 16-bit wrap, result visible one cycle after acc_en.
  logic [15:0] acc_m [3];
  initial for (int i = 0; i < 3; i++) acc_m[i] = '0;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (acc_clr)     acc_m[i] <= '0;
      else if (acc_en) acc_m[i] <= acc_m[i] + ({8'd0, lane_a[8*i +: 8]} * {8'd0, lane_b[8*i +: 8]});
    end
  end
  assign acc_in = {acc_m[2], acc_m[1], acc_m[0]};

  int n_en;
  int n_clr;
  initial begin n_en = 0; n_clr = 0; end
  always @(negedge clk) begin
    if (acc_en)  n_en++;
    if (acc_clr) n_clr++;
  end

  typedef struct {
    logic [3:0]  len;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] a2;
    logic [23:0] b2;
    bit          toggle;
    int          stall;
    bit          poke;
    logic [17:0] want;
  } vec_t;

  vec_t        tbl [6];
  logic [17:0] sb [$];
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {busy, err, in_ready, acc_clr, acc_en, out_valid}, '0);
    chk({tag, "_lanes"}, {lane_a, lane_b}, '0);
    chk({tag, "_sum"}, {46'd0, out_sum}, '0);
  endtask

  task automatic run_job(input vec_t v);
    int          en0, clr0, beats, waited, lat;
    bit          done, first, ph;
    logic [17:0] held, want;
    logic [47:0] pend;
    en0 = n_en; clr0 = n_clr; beats = 0; waited = 0; lat = -1;
    done = 0; first = 1; ph = 0; held = '0; pend = '0;
    sb.push_back(v.want);
    start = 1'b1; len = v.len;
    tick();
    start = v.poke; len = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      in_valid  = v.toggle ? ph : 1'b1;
      ph        = ~ph;
      in_a      = (beats == 0) ? v.a : v.a2;
      in_b      = (beats == 0) ? v.b : v.b2;
      out_ready = (waited >= v.stall);
      @(negedge clk);
      if (v.poke) chk("start_ignored_err", {63'd0, err}, 64'd0);
      if (acc_en) chk("lane_operands", {16'd0, lane_a, lane_b}, {16'd0, pend});
      if (in_valid && in_ready) begin
        pend = {in_a, in_b};
        beats++;
      end
      if (out_valid) begin
        if (first) begin
          first = 0;
          held  = out_sum;
          lat   = c;
        end else begin
          chk("sum_stable", {46'd0, out_sum}, {46'd0, held});
          chk("busy_in_done", {63'd0, busy}, 64'd1);
        end
        if (out_ready) begin
          done = 1;
          chk("sb_level", sb.size(), 1);
          if (sb.size() > 0) begin
            want = sb.pop_front();
            chk("out_sum", {46'd0, out_sum}, {46'd0, want});
          end
        end else begin
          waited++;
        end
      end
      tick();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("job_done", {63'd0, done}, 64'd1);
    // Counted from the edge that samples start: len+MAC_LAT+3 cycles including the start cycle.
    if (!v.toggle) chk("latency", lat, v.len + 3);
    chk("acc_en_count", n_en - en0, v.len);
    chk("acc_clr_count", n_clr - clr0, 1);
    @(negedge clk);
    chk("idle_after_job", {busy, out_valid, err}, 3'b000);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    tbl[0] = '{len: 4'd2,  a: 24'h030201, b: 24'h010101, a2: 24'h010101, b2: 24'h020202,
               toggle: 1'b0, stall: 0, poke: 1'b0, want: 18'd12};
    tbl[1] = '{len: 4'd4,  a: 24'h102030, b: 24'h020202, a2: 24'h102030, b2: 24'h020202,
               toggle: 1'b0, stall: 0, poke: 1'b1, want: 18'd768};
    tbl[2] = '{len: 4'd3,  a: 24'h050505, b: 24'h030303, a2: 24'h050505, b2: 24'h030303,
               toggle: 1'b1, stall: 5, poke: 1'b0, want: 18'd135};
    tbl[3] = '{len: 4'd15, a: 24'hFFFFFF, b: 24'hFFFFFF, a2: 24'hFFFFFF, b2: 24'hFFFFFF,
               toggle: 1'b0, stall: 2, poke: 1'b0, want: 18'd173613};
    tbl[4] = '{len: 4'd7,  a: 24'h0A0B0C, b: 24'h111111, a2: 24'h0A0B0C, b2: 24'h111111,
               toggle: 1'b1, stall: 0, poke: 1'b0, want: 18'd3927};
    tbl[5] = '{len: 4'd1,  a: 24'h030201, b: 24'h010101, a2: 24'h030201, b2: 24'h010101,
               toggle: 1'b0, stall: 1, poke: 1'b1, want: 18'd6};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_job(tbl[i]);

    // Rejected start: one-cycle err, never busy.
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", {63'd0, err}, 64'd1);
    chk("err_not_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("err_one_cycle", {busy, err}, 2'b00);
    tick();

    // Abort on the cycle that carries the final beat.
    start = 1'b1; len = 4'd2; in_a = 24'h010203; in_b = 24'h040506; in_valid = 1'b1;
    tick();
    start = 1'b0; len = '0;
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_at_final_beat", {in_ready, acc_en}, 2'b11);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_to_idle", {busy, acc_en, out_valid, err}, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_result", {out_valid, busy}, 2'b00);
    end
    tick();

    // Reset pulled while draining, then a fresh one-beat job.
    start = 1'b1; len = 4'd1; in_a = 24'h112233; in_b = 24'h010203; in_valid = 1'b1;
    tick();
    start = 1'b0; len = '0;
    tick();
    tick();
    @(negedge clk);
    chk("drain_reached", {busy, in_ready, acc_en}, 3'b101);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    v = '{len: 4'd1, a: 24'h112233, b: 24'h010203, a2: 24'h112233, b2: 24'h010203,
          toggle: 1'b0, stall: 0, poke: 1'b0, want: 18'd238};
    run_job(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter: LEN_W, 4, width of the element-count field.
REQ-002 Parameter: MAC_LAT, 1, cycles from acc_en to a stable acc_in (range 1..7).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low: clk, rst_n.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: start  in  1  begin a job (sampled in IDLE only).
REQ-007 Port: len  in  LEN_W  number of 3-lane operand beats per job.
REQ-008 Port: abort  in  1  synchronous job cancel.
REQ-009 Port: busy  out  1  high in every state except IDLE.
REQ-010 Port: err  out  1  one-cycle pulse on a rejected start.
REQ-011 Port: in_valid / in_ready  in / out  1 / 1  operand-beat handshake.
REQ-012 Port: in_a, in_b  in  24 each  {lane2,lane1,lane0} 8-bit unsigned operands.
REQ-013 Port: lane_a, lane_b  out  24 each  registered operands to the three MAC lanes.
REQ-014 Port: acc_clr  out  1  clear all lane accumulators.
REQ-015 Port: acc_en  out  1  lanes accumulate lane_a*lane_b this cycle.
REQ-016 Port: acc_in  in  48  {lane2,lane1,lane0} 16-bit lane accumulator values.
REQ-017 Port: out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-018 Port: out_sum  out  18  unsigned sum of the three lane accumulators.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 with len!=0 SHALL latch len, zero the beat counter, and go to CLEAR; start=1 with len==0 SHALL pulse err for one cycle and remain in IDLE.
REQ-021 CLEAR SHALL assert acc_clr for exactly one cycle, then go to RUN.
REQ-022 RUN SHALL drive in_ready=1 while beat count < latched len; in_ready SHALL be 0 in all other states.
REQ-023 An accepted beat (in_valid & in_ready) SHALL register in_a/in_b onto lane_a/lane_b and assert acc_en on the next cycle only (one acc_en per beat, no gaps inserted by the controller).
REQ-024 lane_a/lane_b SHALL hold their last values when no beat is accepted.
REQ-025 The beat counter SHALL increment per accepted beat; on the beat making count==len, the FSM SHALL go to DRAIN on the next cycle.
REQ-026 DRAIN SHALL wait MAC_LAT cycles after the final acc_en, then register out_sum = acc_in[15:0]+acc_in[31:16]+acc_in[47:32] (zero-extended, no overflow possible), and go to DONE.
REQ-027 DONE SHALL hold out_valid=1 and out_sum stable until out_ready=1; on that handshake, the FSM SHALL return to IDLE next cycle.
REQ-028 start SHALL be ignored (no err, no restart) when not in IDLE.
REQ-029 abort=1 in any state SHALL return the FSM to IDLE next cycle, with out_valid=0, acc_en=0, and no err; abort has priority over all other events including a same-cycle out_ready or final beat.
REQ-030 A start in the same cycle as the DONE->IDLE handshake SHALL be ignored; a new job starts no earlier than the first IDLE cycle.
REQ-031 Minimum job latency, from start to out_valid with in_valid held high, SHALL be len+MAC_LAT+3 cycles.

Reset
REQ-032 While rst_n=0: FSM=IDLE, busy=0, err=0, in_ready=0, acc_clr=0, acc_en=0, out_valid=0, lane_a=lane_b=0, out_sum=0, counter=0, latched len=0.
REQ-033 Reset asserted mid-job SHALL discard the job; after release, the block SHALL behave as after power-up.

Verification
REQ-034 Basic: start, len=2, beats a=0x030201/b=0x010101, then a=0x010101/b=0x020202, acc model in bench -> acc_clr once, two acc_en pulses, out_sum=12, out_valid at cycle 7 (MAC_LAT=1).
REQ-035 Backpressure: in_valid toggles 1/0 each cycle, len=3 -> exactly 3 acc_en; out_ready held low for 5 cycles -> out_valid and out_sum stable, busy=1.
REQ-036 Max: len=15, all operands 0xFFFFFF -> each lane 15*255*255 truncated to 16 bits by the lanes; out_sum equals the sum of the three 16-bit lane values (max 196605) without wrap.
REQ-037 Errors: start with len=0 -> single-cycle err, busy stays 0; start during RUN -> ignored, no err.
REQ-038 Abort/reset: abort on the final-beat cycle -> IDLE next cycle, no out_valid; rst_n low in DRAIN -> all outputs at reset values immediately (asynchronous), and a subsequent job with len=1 completes correctly.
